// File: rtl/wino_tile_scheduler.sv
// wino_tile_scheduler
// Walks the Winograd input-tile data controller through one layer pass.
// Each input channel id from 0 to total_id-1 gets one handshake:
// prepare -> ready -> start -> finished.
// The block also drives the PE-array qualifiers and reports status
// (busy, done, error, busy-cycle count).
//
// Build option: define WINO_SCHED_WATCHDOG_EN to add a watchdog on the two
// wait states. With it, a wait lasting WDOG_MAX cycles sets err_o and the
// pass returns to IDLE. Without it, the wait states wait indefinitely.
//
// Two copies of the geometry are kept:
// - The cfg copy is written by cfg_wen_i while idle.
// - The active copy is loaded from the cfg copy when a run is accepted.
// A cfg write in the same cycle as an accepted run therefore only affects
// the next pass. The broadcast geometry never changes under a running pass.

module wino_tile_scheduler #(
  parameter int ID_W     = 4,
  parameter int BLK_W    = 8,
  parameter int WDOG_MAX = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  // configuration side
  input  logic             cfg_wen_i,
  input  logic [ID_W-1:0]  cfg_total_id_i,
  input  logic [BLK_W-1:0] cfg_block_width_i,
  input  logic [BLK_W-1:0] cfg_block_height_i,
  input  logic             run_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      busy_cycles_o,
  // input data controller side
  output logic [ID_W-1:0]  input_id_o,
  output logic [BLK_W-1:0] block_width_o,
  output logic [BLK_W-1:0] block_height_o,
  output logic             input_prepare_o,
  output logic             input_start_o,
  input  logic             input_ready_i,
  input  logic             input_finished_i,
  // PE array qualifiers
  output logic             pe_acc_clear_o,
  output logic             pe_last_id_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREP     = 3'd1;
  localparam logic [2:0] S_WAIT_RDY = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_WAIT_FIN = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [ID_W-1:0] ID_ONE  = ID_W'(1);
  localparam logic [ID_W-1:0] ID_ZERO = '0;

  logic [2:0]       state;
  logic [2:0]       state_next;

  // geometry written by the configuration port
  logic [ID_W-1:0]  cfg_total;
  logic [BLK_W-1:0] cfg_width;
  logic [BLK_W-1:0] cfg_height;

  // geometry in use by the current (or last) pass
  logic [ID_W-1:0]  act_total;
  logic [BLK_W-1:0] act_width;
  logic [BLK_W-1:0] act_height;

  logic [ID_W-1:0]  id;
  logic             err;
  logic [31:0]      busy_cycles;

  logic             busy;
  logic             cfg_ok;
  logic             run_accept;
  logic             run_reject;
  logic             abort_hit;
  logic             last_id_hit;
  logic             wdog_expire;
  logic             timeout_hit;
  logic             id_advance;

  assign busy        = (state != S_IDLE);
  assign cfg_ok      = (cfg_total != ID_ZERO) && (cfg_width != '0) && (cfg_height != '0);
  assign run_accept  = (state == S_IDLE) && run_i && cfg_ok;
  assign run_reject  = (state == S_IDLE) && run_i && !cfg_ok;
  assign abort_hit   = busy && abort_i;
  // The total_id-1 compare wraps in ID_W bits on purpose.
  // total_id is never 0 inside a pass, so the wrap cannot alias.
  assign last_id_hit = (id == (act_total - ID_ONE));

  // A watchdog expiry only counts when the awaited response has not arrived in the same cycle.
  // An abort in that cycle takes precedence and leaves err untouched.
  assign timeout_hit = !abort_hit && wdog_expire &&
                       (((state == S_WAIT_RDY) && !input_ready_i) ||
                        ((state == S_WAIT_FIN) && !input_finished_i));

  assign id_advance  = !abort_hit && (state == S_WAIT_FIN) && input_finished_i && !last_id_hit;

`ifdef WINO_SCHED_WATCHDOG_EN
  // Counter is at least 8 bits wide, wider only if WDOG_MAX needs it.
  localparam int WDOG_W = (WDOG_MAX > 255) ? $clog2(WDOG_MAX + 1) : 8;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              waiting;

  assign waiting     = (state == S_WAIT_RDY) || (state == S_WAIT_FIN);
  // wdog_cnt holds the number of cycles already spent in this wait state.
  // The timeout therefore fires on the WDOG_MAX-th cycle of the wait.
  assign wdog_expire = waiting && (wdog_cnt == WDOG_LAST);

  // Restart the watchdog on every state entry; count only while waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt <= '0;
    end else if (state_next != state) begin
      wdog_cnt <= '0;
    end else if (waiting) begin
      wdog_cnt <= wdog_cnt + WDOG_W'(1);
    end
  end
`else
  assign wdog_expire = 1'b0;

  // No timeout logic in this build.
  // WDOG_MAX is still referenced here so both builds accept the same parameter set.
  if (WDOG_MAX < 1) begin : g_wdog_unused
  end
`endif

  // Next-state selection; abort overrides every other transition.
  always_comb begin
    state_next = state;
    if (abort_hit) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (run_accept) begin
            state_next = S_PREP;
          end
        end
        S_PREP: begin
          state_next = S_WAIT_RDY;
        end
        S_WAIT_RDY: begin
          if (input_ready_i) begin
            state_next = S_START;
          end else if (timeout_hit) begin
            state_next = S_IDLE;
          end
        end
        S_START: begin
          state_next = S_WAIT_FIN;
        end
        S_WAIT_FIN: begin
          if (input_finished_i) begin
            state_next = last_id_hit ? S_DONE : S_PREP;
          end else if (timeout_hit) begin
            state_next = S_IDLE;
          end
        end
        S_DONE: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Configuration copy: writable only while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_total  <= '0;
      cfg_width  <= '0;
      cfg_height <= '0;
    end else if ((state == S_IDLE) && cfg_wen_i) begin
      cfg_total  <= cfg_total_id_i;
      cfg_width  <= cfg_block_width_i;
      cfg_height <= cfg_block_height_i;
    end
  end

  // Active geometry: snapshot of the pre-write cfg copy at run acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_total  <= '0;
      act_width  <= '0;
      act_height <= '0;
    end else if (run_accept) begin
      act_total  <= cfg_total;
      act_width  <= cfg_width;
      act_height <= cfg_height;
    end
  end

  // Channel id: cleared on run, advanced on each non-final finished.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id <= '0;
    end else if (run_accept) begin
      id <= '0;
    end else if (id_advance) begin
      id <= id + ID_ONE;
    end
  end

  // Sticky error flag.
  // Set by an illegal run or a watchdog timeout; cleared by an accepted run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (run_accept) begin
      err <= 1'b0;
    end else if (run_reject || timeout_hit) begin
      err <= 1'b1;
    end
  end

  // Busy-cycle counter: restarts per pass, saturates, holds while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_cycles <= '0;
    end else if (run_accept) begin
      busy_cycles <= '0;
    end else if (busy && (busy_cycles != 32'hFFFF_FFFF)) begin
      busy_cycles <= busy_cycles + 32'd1;
    end
  end

  // Outputs are either registers or decodes of the registered state,
  // so no input reaches an output combinationally.
  assign busy_o          = busy;
  assign done_o          = (state == S_DONE);
  assign err_o           = err;
  assign busy_cycles_o   = busy_cycles;
  assign input_id_o      = id;
  assign block_width_o   = act_width;
  assign block_height_o  = act_height;
  assign input_prepare_o = (state == S_PREP);
  assign input_start_o   = (state == S_START);
  assign pe_acc_clear_o  = (state == S_START) && (id == ID_ZERO);
  assign pe_last_id_o    = busy && last_id_hit;

endmodule
